adc_rd_ctrl: RTL and testbench

//  Sequencer for one serial ADC read: pulses CNV, waits conversion time, generates

---
 rtl/adc_ctrl_pkg.sv | 29 ++
 rtl/adc_rd_ctrl_if.sv | 28 ++
 rtl/adc_cnt_sync.sv | 31 +++
 rtl/adc_rd_ctrl.sv | 154 +++++++++++++++
 tb/tb_adc_rd_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_ctrl_pkg.sv
// Shared types for the serial ADC read controller.
//   state_e   : controller FSM encoding (IDLE/CONV/SHIFT/DONE)
//   cnt_opc_e : 2-bit counter opcode used by the team's opcode counters
//               (2'b11 is not listed and behaves as CLR)
//   max3      : helper used to size-check the counter width at elaboration
package adc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OPC_CLR  = 2'b00,
    OPC_HOLD = 2'b01,
    OPC_INC  = 2'b10
  } cnt_opc_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_rd_ctrl_if.sv
// Request/response bundle between the pixel-matrix scan FSM and adc_rd_ctrl.
//   start_i : request one read (scan FSM -> controller)
//   cont_i  : continuous mode  (scan FSM -> controller)
//   busy_o  : controller not idle
//   done_o  : 1-cycle strobe, data_o valid from this cycle
//   data_o  : last completed conversion word
// Suffixes are relative to the controller, matching its historic port names.
interface adc_rd_ctrl_if #(
  parameter int unsigned DataWidth = 16
);

  logic                 start_i;
  logic                 cont_i;
  logic                 busy_o;
  logic                 done_o;
  logic [DataWidth-1:0] data_o;

  modport master (
    output start_i, cont_i,
    input  busy_o, done_o, data_o
  );

  modport slave (
    input  start_i, cont_i,
    output busy_o, done_o, data_o
  );

endinterface

// File: rtl/adc_cnt_sync.sv
// Opcode-driven up-counter with synchronous active-low reset.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset, clears the count
//   opc_i  : OPC_CLR / OPC_HOLD / OPC_INC (unlisted code clears)
//   cnt_o  : current count
module adc_cnt_sync
  import adc_ctrl_pkg::*;
#(
  parameter int unsigned CntWidth = 6
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  cnt_opc_e            opc_i,
  output logic [CntWidth-1:0] cnt_o
);

  // NOTE: state is updated with non-blocking assignments so every flop in the
  // design samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else begin
      case (opc_i)
        OPC_INC:  cnt_o <= cnt_o + 1'b1;
        OPC_HOLD: cnt_o <= cnt_o;
        default:  cnt_o <= '0;
      endcase
    end
  end

endmodule

// File: rtl/adc_rd_ctrl.sv
// Sequencer for one serial ADC read: pulses CNV for the conversion time,
// generates DCLK, shifts in DataWidth bits MSB-first and presents the word
// with a 1-cycle done strobe. Optionally loops straight back into CONV.
//   clk_i  : system clock, all logic on posedge
//   rst_ni : synchronous active-low reset
//   bus    : scan-FSM side (start_i, cont_i, busy_o, done_o, data_o)
//   sdo_i  : ADC serial data out
//   cnv_o  : ADC conversion start, active high
//   dclk_o : ADC serial clock, idle low
// All outputs come straight from flops; each is loaded from the next-state
// decode so it lines up with the state it belongs to.
module adc_rd_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int unsigned DataWidth  = 16,
  parameter int unsigned ConvCycles = 40,
  parameter int unsigned HalfPer    = 2,
  parameter int unsigned CntWidth   = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  adc_rd_ctrl_if.slave  bus,
  input  logic          sdo_i,
  output logic          cnv_o,
  output logic          dclk_o
);

  // The bit counter ends one past DataWidth-1, so every limit must stay
  // strictly below 2**CntWidth.
  localparam int unsigned CntNeed = max3(ConvCycles, DataWidth, 2 * HalfPer);

  if (CntNeed >= (1 << CntWidth) || ConvCycles < 1 || HalfPer < 1 || DataWidth < 2)
  begin : g_bad_cfg
    $error("adc_rd_ctrl: parameter set out of range");
  end

  localparam logic [CntWidth-1:0] ConvLast = CntWidth'(ConvCycles - 1);
  localparam logic [CntWidth-1:0] BitLast  = CntWidth'(DataWidth - 1);
  localparam logic [CntWidth-1:0] PhLast   = CntWidth'(2 * HalfPer - 1);
  localparam logic [CntWidth:0]   PhHigh   = (CntWidth + 1)'(HalfPer);

  state_e               state_q, state_d;
  cnt_opc_e             wait_opc, ph_opc;
  logic [CntWidth-1:0]  wait_cnt, ph_cnt;
  logic [CntWidth:0]    ph_inc;
  logic                 ph_wrap, sample, dclk_d;
  logic [DataWidth-1:0] sreg_q, sreg_d, data_q;
  logic                 cnv_q, dclk_q, busy_q, done_q;

  // Wait counter doubles as the bit counter in SHIFT.
  adc_cnt_sync #(.CntWidth(CntWidth)) u_wait_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .opc_i  (wait_opc),
    .cnt_o  (wait_cnt)
  );

  // DCLK phase counter: 0..2*HalfPer-1, low half first.
  adc_cnt_sync #(.CntWidth(CntWidth)) u_ph_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .opc_i  (ph_opc),
    .cnt_o  (ph_cnt)
  );

  assign ph_wrap = (ph_cnt == PhLast);
  assign ph_inc  = {1'b0, ph_cnt} + 1'b1;
  // Bits are taken on the last phase, i.e. right before DCLK falls and the
  // ADC moves on to the next bit.
  assign sample  = (state_q == SHIFT) && ph_wrap;
  assign sreg_d  = {sreg_q[DataWidth-2:0], sdo_i};
  // DCLK level for the next cycle is the high half of the next phase value.
  assign dclk_d  = (state_q == SHIFT) && !ph_wrap && (ph_inc >= PhHigh);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    wait_opc = OPC_HOLD;
    ph_opc   = OPC_HOLD;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d  = CONV;
          wait_opc = OPC_CLR;
        end
      end
      CONV: begin
        if (wait_cnt == ConvLast) begin
          state_d  = SHIFT;
          wait_opc = OPC_CLR;
          ph_opc   = OPC_CLR;
        end else begin
          wait_opc = OPC_INC;
        end
      end
      SHIFT: begin
        if (ph_wrap) begin
          ph_opc   = OPC_CLR;
          wait_opc = OPC_INC;
          if (wait_cnt == BitLast) begin
            state_d = DONE;
          end
        end else begin
          ph_opc = OPC_INC;
        end
      end
      DONE: begin
        wait_opc = OPC_CLR;
        ph_opc   = OPC_CLR;
        // cont_i wins over start_i here; start_i is only looked at in IDLE.
        state_d  = bus.cont_i ? CONV : IDLE;
      end
      default: begin
        state_d  = IDLE;
        wait_opc = OPC_CLR;
        ph_opc   = OPC_CLR;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      data_q  <= '0;
      cnv_q   <= 1'b0;
      dclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnv_q   <= (state_d == CONV);
      dclk_q  <= dclk_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (sample) begin
        sreg_q <= sreg_d;
      end
      // The last bit arrives on the same edge that enters DONE, so the word is
      // taken from the shift input rather than the register.
      if (sample && state_d == DONE) begin
        data_q <= sreg_d;
      end
    end
  end

  assign cnv_o      = cnv_q;
  assign dclk_o     = dclk_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_adc_rd_ctrl.sv
// Directed bench for adc_rd_ctrl: default configuration (16/40/2) plus a
// minimal configuration (4/1/1). Simple ADC models drive sdo on DCLK falls.
module tb_adc_rd_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adc_rd_ctrl_if #(.DataWidth(16)) bus ();
  adc_rd_ctrl_if #(.DataWidth(4))  bus4 ();

  logic sdo, cnv, dclk;
  logic sdo4, cnv4, dclk4;

  adc_rd_ctrl #(
    .DataWidth(16), .ConvCycles(40), .HalfPer(2), .CntWidth(6)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .sdo_i  (sdo),
    .cnv_o  (cnv),
    .dclk_o (dclk)
  );

  adc_rd_ctrl #(
    .DataWidth(4), .ConvCycles(1), .HalfPer(1), .CntWidth(6)
  ) dut4 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus4),
    .sdo_i  (sdo4),
    .cnv_o  (cnv4),
    .dclk_o (dclk4)
  );

  // ---------------- ADC models ----------------
  logic [15:0] words [3];
  int          conv_base = 0;
  int          conv_n    = 0;
  int          bit_idx   = 0;
  logic [15:0] cur_word  = '0;
  logic        sdo_model = 1'b0;
  logic        cnv_prev  = 1'b0;
  logic        dclk_prev = 1'b0;
  logic        noise_en  = 1'b0;
  logic        sdo_noise = 1'b0;

  assign sdo = noise_en ? sdo_noise : sdo_model;

  // MSB appears when CNV falls; each DCLK fall advances one bit.
  always @(cnv or dclk) begin
    if (cnv_prev && !cnv) begin
      if ((conv_n - conv_base) >= 0 && (conv_n - conv_base) < 3)
        cur_word = words[conv_n - conv_base];
      else
        cur_word = 16'h0000;
      conv_n++;
      bit_idx   = 15;
      sdo_model = cur_word[15];
    end else if (dclk_prev && !dclk && bit_idx > 0) begin
      bit_idx--;
      sdo_model = cur_word[bit_idx];
    end
    cnv_prev  = cnv;
    dclk_prev = dclk;
  end

  logic [3:0] word4      = 4'b1001;
  int         bit4_idx   = 0;
  logic       cnv4_prev  = 1'b0;
  logic       dclk4_prev = 1'b0;
  logic       sdo4_q     = 1'b0;
  assign sdo4 = sdo4_q;

  always @(cnv4 or dclk4) begin
    if (cnv4_prev && !cnv4) begin
      bit4_idx = 3;
      sdo4_q   = word4[3];
    end else if (dclk4_prev && !dclk4 && bit4_idx > 0) begin
      bit4_idx--;
      sdo4_q = word4[bit4_idx];
    end
    cnv4_prev  = cnv4;
    dclk4_prev = dclk4;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- observation ----------------
  int          done_cyc  [4];
  logic [15:0] done_data [4];
  int          rise_cyc  [4];
  int          n_done, n_rise, cnv_hi, dclk_hi, dclk_rise, busy_low, busy_after;

  // Launch a read; returns at the falling edge of cycle 1 (the cycle right
  // after the edge that samples start_i).
  task automatic do_start();
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  // Samples cycles 1..n_cyc at falling edges. start_i is pulsed after cycles
  // pulse_a/pulse_b, cont_i drops after cycle cont_drop. busy_low counts idle
  // cycles within 1..busy_win; busy_after is busy_o in cycle busy_win+1.
  task automatic observe(input int n_cyc, input int pulse_a, input int pulse_b,
                         input int cont_drop, input int busy_win);
    logic cnv_last, dclk_last;
    cnv_last = 1'b0; dclk_last = 1'b0;
    n_done = 0; n_rise = 0; cnv_hi = 0; dclk_hi = 0; dclk_rise = 0;
    busy_low = 0; busy_after = -1;
    for (int j = 0; j < 4; j++) begin
      done_cyc[j] = 0; done_data[j] = '0; rise_cyc[j] = 0;
    end
    for (int i = 1; i <= n_cyc; i++) begin
      if (bus.done_o) begin
        if (n_done < 4) begin
          done_cyc[n_done]  = i;
          done_data[n_done] = bus.data_o;
        end
        n_done++;
      end
      if (cnv && !cnv_last) begin
        if (n_rise < 4) rise_cyc[n_rise] = i;
        n_rise++;
      end
      if (cnv) cnv_hi++;
      if (dclk) dclk_hi++;
      if (dclk && !dclk_last) dclk_rise++;
      if (!bus.busy_o && i <= busy_win) busy_low++;
      if (i == busy_win + 1) busy_after = int'(bus.busy_o);
      cnv_last  = cnv;
      dclk_last = dclk;
      bus.start_i = (i == pulse_a) || (i == pulse_b);
      if (i == cont_drop) bus.cont_i = 1'b0;
      @(negedge clk);
    end
    bus.start_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          changes;
    int          done4_cyc, cnv4_hi;
    logic [3:0]  data4;

    bus.start_i  = 1'b0;
    bus.cont_i   = 1'b0;
    bus4.start_i = 1'b0;
    bus4.cont_i  = 1'b0;
    words[0] = 16'h0000; words[1] = 16'h0000; words[2] = 16'h0000;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_outputs", {cnv, dclk, bus.busy_o, bus.done_o}, 4'b0000);
    check("rst_data", bus.data_o, 16'h0000);
    check("rst_outputs_small", {cnv4, dclk4, bus4.busy_o, bus4.done_o, bus4.data_o}, 8'h00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_start", {cnv, dclk, bus.busy_o, bus.done_o}, 4'b0000);

    // Single read of 0xA5C3
    words[0]  = 16'hA5C3;
    conv_base = conv_n;
    do_start();
    observe(130, 0, 0, 0, 105);
    check("single_n_done",    n_done, 1);
    check("single_done_cyc",  done_cyc[0], 105);
    check("single_data",      done_data[0], 16'hA5C3);
    check("single_cnv_rise",  rise_cyc[0], 1);
    check("single_cnv_hi",    cnv_hi, 40);
    check("single_dclk_hi",   dclk_hi, 32);
    check("single_dclk_rise", dclk_rise, 16);
    check("single_busy_gap",  busy_low, 0);
    check("single_busy_after", busy_after, 0);

    // Data hold while sdo toggles in IDLE
    noise_en = 1'b1;
    changes  = 0;
    for (int i = 0; i < 30; i++) begin
      sdo_noise = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.data_o !== 16'hA5C3) changes++;
    end
    noise_en = 1'b0;
    check("hold_data_changes", changes, 0);
    check("hold_data", bus.data_o, 16'hA5C3);
    check("hold_idle", {cnv, bus.busy_o, bus.done_o}, 3'b000);

    // start_i pulsed during CONV and SHIFT is ignored
    conv_base = conv_n;
    do_start();
    observe(140, 10, 60, 0, 105);
    check("ign_n_done",   n_done, 1);
    check("ign_done_cyc", done_cyc[0], 105);
    check("ign_data",     done_data[0], 16'hA5C3);
    check("ign_cnv_rise", n_rise, 1);

    // Continuous mode, three words back to back
    words[0] = 16'h0001; words[1] = 16'hFFFF; words[2] = 16'h8000;
    conv_base  = conv_n;
    bus.cont_i = 1'b1;
    do_start();
    observe(340, 0, 0, 220, 315);
    check("cont_n_done",  n_done, 3);
    check("cont_done0",   done_cyc[0], 105);
    check("cont_done1",   done_cyc[1], 210);
    check("cont_done2",   done_cyc[2], 315);
    check("cont_data0",   done_data[0], 16'h0001);
    check("cont_data1",   done_data[1], 16'hFFFF);
    check("cont_data2",   done_data[2], 16'h8000);
    check("cont_rise0",   rise_cyc[0], 1);
    check("cont_rise1",   rise_cyc[1], 106);
    check("cont_rise2",   rise_cyc[2], 211);
    check("cont_no_idle", busy_low, 0);
    check("cont_stop",    busy_after, 0);

    // Reset in the middle of SHIFT
    words[0]  = 16'h5A5A;
    conv_base = conv_n;
    do_start();
    repeat (60) @(negedge clk);
    check("mid_busy_before_rst", bus.busy_o, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_outputs", {cnv, dclk, bus.busy_o, bus.done_o}, 4'b0000);
    check("mid_rst_data", bus.data_o, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    observe(20, 0, 0, 0, 20);
    check("post_rst_idle",   busy_low, 20);
    check("post_rst_no_cnv", cnv_hi, 0);
    check("post_rst_no_done", n_done, 0);

    // Minimal configuration: 4 bits, 1 conversion cycle, 1-cycle half period
    @(negedge clk);
    bus4.start_i = 1'b1;
    @(negedge clk);
    bus4.start_i = 1'b0;
    done4_cyc = 0; data4 = '0; cnv4_hi = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus4.done_o && done4_cyc == 0) begin
        done4_cyc = i;
        data4     = bus4.data_o;
      end
      if (cnv4) cnv4_hi++;
      @(negedge clk);
    end
    check("small_done_cyc", done4_cyc, 10);
    check("small_data",     data4, 4'h9);
    check("small_cnv_hi",   cnv4_hi, 1);
    check("small_idle",     bus4.busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
